write_buffered: RTL

//  Parametrised write-back stage. Commits ALU/load results to the register file,

---
 rtl/write_buffered.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/write_buffered.sv
// Write-back stage: commits results to the register file, redirects the PC, forwards results
// and queues stores in a FIFO drained over a req/ack port. Define WB_STORE_COALESCE_EN to merge same-address stores.
module write_buffered #(
    parameter int XLEN        = 32,
    parameter int NUM_REGS    = 16,
    parameter int PC_IDX      = 15,
    parameter int FLAGS_IDX   = 14,
    parameter int FLAGS_W     = 4,
    parameter int STORE_DEPTH = 4,
    localparam int REG_IDX_W  = $clog2(NUM_REGS),
    localparam int CNT_W      = $clog2(STORE_DEPTH) + 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     hold,
    input  logic [REG_IDX_W-1:0]     in_dest,
    input  logic [XLEN-1:0]          in_value,
    input  logic [XLEN-1:0]          in_upper_value,
    input  logic                     in_has_upper,
    input  logic                     in_is_store,
    input  logic [XLEN-1:0]          in_adjust,
    input  logic [FLAGS_W-1:0]       in_flags,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          next_pc,
    input  logic [NUM_REGS*XLEN-1:0] regs_in,
    output logic [NUM_REGS*XLEN-1:0] regs_out,
    output logic                     mem_req,
    output logic [XLEN-1:0]          mem_addr,
    output logic [XLEN-1:0]          mem_data,
    input  logic                     mem_ack,
    output logic                     fb_valid,
    output logic [REG_IDX_W-1:0]     fb_index,
    output logic [XLEN-1:0]          fb_value,
    output logic [XLEN-1:0]          fb_upper_value,
    output logic                     fb_has_upper,
    output logic [CNT_W-1:0]         sq_count,
    output logic                     sq_empty
);

    localparam int PTR_W = (STORE_DEPTH > 1) ? $clog2(STORE_DEPTH) : 1;

    logic [XLEN-1:0]      regs_in_arr [NUM_REGS];
    logic [XLEN-1:0]      merged      [NUM_REGS];
    logic [XLEN-1:0]      regs_reg    [NUM_REGS];
    logic [REG_IDX_W:0]   upper_idx;
    logic                 accept;
    logic                 pc_write;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 coalesce_hit;
    logic [XLEN-1:0]      store_addr;
    logic                 unused_regs;

    logic [XLEN-1:0]      sq_addr_mem [STORE_DEPTH];
    logic [XLEN-1:0]      sq_data_mem [STORE_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [CNT_W-1:0]     count_reg;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(STORE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Extra bit keeps dest==NUM_REGS-1 from wrapping the upper write onto register 0.
    assign upper_idx = {1'b0, in_dest} + (REG_IDX_W + 1)'(1);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            assign regs_in_arr[gi]              = regs_in[gi*XLEN +: XLEN];
            assign regs_out[gi*XLEN +: XLEN]    = regs_reg[gi];
            if (gi == 0) begin : g_zero
                assign merged[gi] = '0;
            end else if (gi == PC_IDX) begin : g_pc
                assign merged[gi] = in_pc;
            end else if (gi == FLAGS_IDX) begin : g_flags
                assign merged[gi] = (!in_is_store && in_dest == REG_IDX_W'(gi)) ? in_value :
                                    {regs_in_arr[gi][XLEN-1], in_flags,
                                     regs_in_arr[gi][XLEN-FLAGS_W-2:0]};
            end else begin : g_gpr
                assign merged[gi] = (!in_is_store && in_dest == REG_IDX_W'(gi)) ? in_value :
                                    (!in_is_store && in_has_upper &&
                                     upper_idx == (REG_IDX_W + 1)'(gi)) ? in_upper_value :
                                    regs_in_arr[gi];
            end
        end
    endgenerate

    // Register 0, the incoming PC slot and the old flag field are replaced, never read.
    assign unused_regs = ^{regs_in_arr[0], regs_in_arr[PC_IDX],
                           regs_in_arr[FLAGS_IDX][XLEN-2 -: FLAGS_W]};

    assign store_addr = merged[in_dest] + in_adjust;
    assign full       = (count_reg == CNT_W'(STORE_DEPTH));
    assign sq_empty   = (count_reg == '0);
    assign sq_count   = count_reg;
    assign mem_req    = !sq_empty;
    assign mem_addr   = sq_addr_mem[rd_ptr_reg];
    assign mem_data   = sq_data_mem[rd_ptr_reg];
    assign pop        = mem_req && mem_ack;

`ifdef WB_STORE_COALESCE_EN
    logic [PTR_W-1:0] young_ptr;
    assign young_ptr = (wr_ptr_reg == '0) ? PTR_W'(STORE_DEPTH - 1) : wr_ptr_reg - PTR_W'(1);
    // With two or more entries the youngest is never the head being presented to memory.
    assign coalesce_hit = in_is_store && (STORE_DEPTH > 1) && (count_reg > CNT_W'(1)) &&
                          (sq_addr_mem[young_ptr] == store_addr);
`else
    assign coalesce_hit = 1'b0;
`endif

    assign hold     = in_valid && in_is_store && full && !coalesce_hit;
    assign accept   = in_valid && !hold;
    assign pc_write = accept && !in_is_store && (in_dest == REG_IDX_W'(PC_IDX));
    assign push     = accept && in_is_store && !coalesce_hit;

    assign fb_valid       = in_valid && !in_is_store;
    assign fb_index       = in_dest;
    assign fb_value       = in_value;
    assign fb_upper_value = in_upper_value;
    assign fb_has_upper   = in_has_upper;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == PC_IDX) begin
                    regs_reg[i] <= pc_write ? in_value : next_pc;
                end else if (accept) begin
                    regs_reg[i] <= merged[i];
                end
            end
        end
    end

    // Storage carries no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            sq_addr_mem[wr_ptr_reg] <= store_addr;
            sq_data_mem[wr_ptr_reg] <= in_value;
        end
`ifdef WB_STORE_COALESCE_EN
        if (accept && coalesce_hit) begin
            sq_data_mem[young_ptr] <= in_value;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

endmodule
